change_dispenser: RTL and testbench
===================================

# change_dispenser

Parametrised change-dispensing controller for the vending datapath; it supersedes the fixed 2/10-euro giver. On `start` it accepts an amount and pays it out greedily, one item at a time: large notes first, then coins. Each item is issued through a req/ack handshake with the dispensing mechanism. The block keeps per-denomination stock counters, reports shortfall when it cannot finish, and sits between the payment/price logic and the physical dispenser drivers.

## Interface
Parameters:
- `AMOUNT_W`, 6, width of `amount` and `remaining`.
- `COUNT_W`, 5, width of each stock counter.
- `COIN_VAL`, 2, coin value. Constraint: 0 < `COIN_VAL` < `NOTE_VAL`.
- `NOTE_VAL`, 10, note value. Constraint: `NOTE_VAL` < 2^`AMOUNT_W`.
- `NOTE_INIT`, 10, note stock after reset.
- `COIN_INIT`, 20, coin stock after reset.
- `TIMEOUT_CYCLES`, 16, ack wait limit. Used only with `CHANGE_DISPENSER_TIMEOUT_EN`.

Ports:
- `clock` in 1: the only clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request payout of `amount`. Sampled only in IDLE.
- `amount` in `AMOUNT_W`: value to pay, sampled with `start`.
- `refill` in 1: load `note_load`/`coin_load` into stock. Honoured only in IDLE.
- `note_load`, `coin_load` in `COUNT_W`: refill values.
- `item_ack` in 1: mechanism has released the requested item.
- `busy` out 1: high in every state except IDLE.
- `note_req`, `coin_req` out 1: item request. Held until acked; never both high.
- `done` out 1: one-cycle completion pulse.
- `error` out 1: high together with `done` when payout is incomplete.
- `remaining` out `AMOUNT_W`: amount still owed.
- `note_stock`, `coin_stock` out `COUNT_W`: current stock.

## Operation
- States: IDLE, SELECT, NOTE_WAIT, COIN_WAIT, DONE.
- IDLE to SELECT: on `start`, with `remaining` <= `amount`.
- SELECT:
  - If `remaining` == 0: go to DONE with error=0.
  - Else if `remaining` >= `NOTE_VAL` and `note_stock` != 0: go to NOTE_WAIT and assert `note_req`.
  - Else if `remaining` >= `COIN_VAL` and `coin_stock` != 0: go to COIN_WAIT and assert `coin_req`.
  - Else: go to DONE with error=1.
- NOTE_WAIT/COIN_WAIT: hold req. On the cycle `item_ack` is sampled high:
  - Drop req.
  - `remaining` -= item value.
  - Matching stock -= 1.
  - Return to SELECT.
- DONE: `done`=1 for one cycle, `error` as latched, then IDLE. `remaining` holds the shortfall until the next `start`.
- Arithmetic: compares and subtracts are unsigned, with parameter values zero-extended to `AMOUNT_W`. Subtraction cannot underflow because of the SELECT guards. Stock never decrements below 0.
- Ignored inputs:
  - `start` while `busy`.
  - `item_ack` in IDLE, SELECT or DONE.
  - `refill` while `busy`.
- `refill` and `start` in the same IDLE cycle: both are taken. SELECT sees the new stock.
- `amount` that is not a multiple of `COIN_VAL` pays what it can, then ends with error=1 and a nonzero `remaining`.

## Timing
- Reset values:
  - state IDLE.
  - `busy`, `note_req`, `coin_req`, `done`, `error` = 0.
  - `remaining` = 0.
  - `note_stock` = `NOTE_INIT`, `coin_stock` = `COIN_INIT`.
- Reset mid-payout: return to IDLE at the next edge and drop req. No `done` pulse. Stock keeps already-dispensed decrements, then is reinitialised by reset.
- Request timing: `start` sampled at edge t → SELECT from t+1 → req high from t+2.
- Per-item cost: 2 cycles from req rising, assuming immediate ack (req at n, ack sampled at n, SELECT at n+1, next req at n+2).
- `amount`=0: `done` high during cycle t+2.
- All outputs are registered.

## Configuration
- `CHANGE_DISPENSER_TIMEOUT_EN` defined:
  - A counter runs in NOTE_WAIT/COIN_WAIT and clears on entry.
  - If `TIMEOUT_CYCLES` cycles pass without `item_ack`, drop req, leave `remaining` and stock unchanged, and go to DONE with error=1.
  - An ack arriving on the expiry cycle wins over the timeout.
- Not defined: no counter. The WAIT states hold req indefinitely.

## Test plan
- Default params, amount=28, ack 1 cycle after each req → 2 notes then 4 coins. `done`=1, `error`=0, `remaining`=0, stocks 8/16.
- Refill notes=1, coins=20, then amount=24 → 1 note, 7 coins, error=0, stocks 0/13.
- amount=7 → 3 coins, then `done` with `error`=1 and `remaining`=1.
- amount=0 → `done` at t+2, no req, `error`=0.
- With `CHANGE_DISPENSER_TIMEOUT_EN`, amount=10, never ack → req drops after 16 cycles, error=1, `remaining`=10, `note_stock`=10.
- Assert `reset` while `coin_req` is high → req low next cycle, no `done`, stocks back to 10/20. Then `start` with amount=2 works normally.

Source files
------------

// File: rtl/change_dispenser.sv
// Greedy change dispenser: pays an amount in notes then coins via req/ack, tracking stock per denomination.
// Optional CHANGE_DISPENSER_TIMEOUT_EN aborts a payout when an item is not acked within TIMEOUT_CYCLES.
module change_dispenser #(
    parameter int AMOUNT_W       = 6,
    parameter int COUNT_W        = 5,
    parameter int COIN_VAL       = 2,
    parameter int NOTE_VAL       = 10,
    parameter int NOTE_INIT      = 10,
    parameter int COIN_INIT      = 20,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [AMOUNT_W-1:0] amount,
    input  logic                refill,
    input  logic [COUNT_W-1:0]  note_load,
    input  logic [COUNT_W-1:0]  coin_load,
    input  logic                item_ack,
    output logic                busy,
    output logic                note_req,
    output logic                coin_req,
    output logic                done,
    output logic                error,
    output logic [AMOUNT_W-1:0] remaining,
    output logic [COUNT_W-1:0]  note_stock,
    output logic [COUNT_W-1:0]  coin_stock
);

    localparam logic [AMOUNT_W-1:0] NOTE_V = AMOUNT_W'(NOTE_VAL);
    localparam logic [AMOUNT_W-1:0] COIN_V = AMOUNT_W'(COIN_VAL);
    localparam logic [COUNT_W-1:0]  NOTE_S = COUNT_W'(NOTE_INIT);
    localparam logic [COUNT_W-1:0]  COIN_S = COUNT_W'(COIN_INIT);

    if (COIN_VAL <= 0 || COIN_VAL >= NOTE_VAL || NOTE_VAL >= (1 << AMOUNT_W) || TIMEOUT_CYCLES < 1)
    begin : g_param_check
        $error("change_dispenser: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        NOTE_WAIT,
        COIN_WAIT,
        DONE
    } state_t;

    state_t              state, state_nxt;
    logic [AMOUNT_W-1:0] remaining_nxt;
    logic [COUNT_W-1:0]  note_stock_nxt, coin_stock_nxt;
    logic                error_nxt;

`ifdef CHANGE_DISPENSER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] wait_cnt, wait_cnt_nxt;
`endif

    always_comb begin
        state_nxt      = state;
        remaining_nxt  = remaining;
        note_stock_nxt = note_stock;
        coin_stock_nxt = coin_stock;
        error_nxt      = 1'b0;
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
        wait_cnt_nxt   = '0;
`endif
        case (state)
            IDLE: begin
                if (refill) begin
                    note_stock_nxt = note_load;
                    coin_stock_nxt = coin_load;
                end
                if (start) begin
                    remaining_nxt = amount;
                    state_nxt     = SELECT;
                end
            end
            SELECT: begin
                if (remaining == '0) begin
                    state_nxt = DONE;
                end else if (remaining >= NOTE_V && note_stock != '0) begin
                    state_nxt = NOTE_WAIT;
                end else if (remaining >= COIN_V && coin_stock != '0) begin
                    state_nxt = COIN_WAIT;
                end else begin
                    state_nxt = DONE;
                    error_nxt = 1'b1;
                end
            end
            NOTE_WAIT: begin
                if (item_ack) begin
                    remaining_nxt  = remaining - NOTE_V;
                    note_stock_nxt = note_stock - 1'b1;
                    state_nxt      = SELECT;
                end
            end
            COIN_WAIT: begin
                if (item_ack) begin
                    remaining_nxt  = remaining - COIN_V;
                    coin_stock_nxt = coin_stock - 1'b1;
                    state_nxt      = SELECT;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
        // An ack on the expiry cycle is handled above and takes priority.
        if ((state == NOTE_WAIT || state == COIN_WAIT) && !item_ack) begin
            if (wait_cnt == WAIT_LAST) begin
                state_nxt = DONE;
                error_nxt = 1'b1;
            end else begin
                wait_cnt_nxt = wait_cnt + 1'b1;
            end
        end
`endif
    end

    // Outputs are registered from the next-state decode so req/done/busy align with the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            note_req   <= 1'b0;
            coin_req   <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            remaining  <= '0;
            note_stock <= NOTE_S;
            coin_stock <= COIN_S;
        end else begin
            state      <= state_nxt;
            busy       <= (state_nxt != IDLE);
            note_req   <= (state_nxt == NOTE_WAIT);
            coin_req   <= (state_nxt == COIN_WAIT);
            done       <= (state_nxt == DONE);
            error      <= error_nxt;
            remaining  <= remaining_nxt;
            note_stock <= note_stock_nxt;
            coin_stock <= coin_stock_nxt;
        end
    end

`ifdef CHANGE_DISPENSER_TIMEOUT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized bench for change_dispenser against an arithmetic greedy-payout model.
module tb_change_dispenser;

    localparam int AMOUNT_W       = 6;
    localparam int COUNT_W        = 5;
    localparam int COIN_VAL       = 2;
    localparam int NOTE_VAL       = 10;
    localparam int NOTE_INIT      = 10;
    localparam int COIN_INIT      = 20;
    localparam int TIMEOUT_CYCLES = 16;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                start = 1'b0;
    logic [AMOUNT_W-1:0] amount = '0;
    logic                refill = 1'b0;
    logic [COUNT_W-1:0]  note_load = '0;
    logic [COUNT_W-1:0]  coin_load = '0;
    logic                item_ack = 1'b0;
    logic                busy, note_req, coin_req, done, error;
    logic [AMOUNT_W-1:0] remaining;
    logic [COUNT_W-1:0]  note_stock, coin_stock;

    change_dispenser #(
        .AMOUNT_W(AMOUNT_W), .COUNT_W(COUNT_W), .COIN_VAL(COIN_VAL), .NOTE_VAL(NOTE_VAL),
        .NOTE_INIT(NOTE_INIT), .COIN_INIT(COIN_INIT), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .amount(amount), .refill(refill),
        .note_load(note_load), .coin_load(coin_load), .item_ack(item_ack),
        .busy(busy), .note_req(note_req), .coin_req(coin_req), .done(done), .error(error),
        .remaining(remaining), .note_stock(note_stock), .coin_stock(coin_stock)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int ack_delay = 0;
    bit ack_en = 1'b1;
    int note_items = 0, coin_items = 0, both_err = 0, order_err = 0;
    int m_ns, m_cs;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Mechanism model: acks each request ack_delay cycles after it rises, logs item kinds.
    initial begin
        int  wait_n;
        bit  coin_seen;
        wait_n = 0;
        coin_seen = 1'b0;
        forever begin
            @(negedge clock);
            if (note_req && coin_req) both_err++;
            if (!busy) coin_seen = 1'b0;
            if (note_req && coin_seen) order_err++;
            if (coin_req) coin_seen = 1'b1;
            if (ack_en && (note_req || coin_req)) begin
                if (wait_n >= ack_delay) begin
                    item_ack = 1'b1;
                    if (note_req) note_items++;
                    else coin_items++;
                    wait_n = 0;
                end else begin
                    item_ack = 1'b0;
                    wait_n++;
                end
            end else begin
                item_ack = 1'b0;
                wait_n = 0;
            end
        end
    end

    task automatic do_refill(input int nl, input int cl);
        @(posedge clock); #1;
        refill = 1'b1; note_load = nl[COUNT_W-1:0]; coin_load = cl[COUNT_W-1:0];
        @(posedge clock); #1;
        refill = 1'b0;
        m_ns = nl; m_cs = cl;
        @(negedge clock);
        check_eq("refill.note_stock", int'(note_stock), m_ns);
        check_eq("refill.coin_stock", int'(coin_stock), m_cs);
    endtask

    task automatic do_payout(input string tag, input int amt, input int dly,
                             input bit rf, input int nl, input int cl, input bit poke);
        int en, ec, r, n0, c0, cyc;
        bit got;
        if (rf) begin m_ns = nl; m_cs = cl; end
        en = amt / NOTE_VAL;
        if (en > m_ns) en = m_ns;
        r = amt - en * NOTE_VAL;
        ec = r / COIN_VAL;
        if (ec > m_cs) ec = m_cs;
        r = r - ec * COIN_VAL;
        n0 = note_items; c0 = coin_items;
        ack_delay = dly; ack_en = 1'b1;
        @(posedge clock); #1;
        start = 1'b1; amount = amt[AMOUNT_W-1:0];
        refill = rf; note_load = nl[COUNT_W-1:0]; coin_load = cl[COUNT_W-1:0];
        @(posedge clock); #1;
        start = 1'b0; refill = 1'b0; amount = AMOUNT_W'($urandom);
        got = 1'b0; cyc = 0;
        while (!got && cyc < 3000) begin
            @(negedge clock);
            if (poke && cyc == 2) begin
                start = 1'b1; amount = AMOUNT_W'(4); refill = 1'b1; note_load = '0; coin_load = '0;
            end else if (poke && cyc == 3) begin
                start = 1'b0; refill = 1'b0;
            end
            if (done) got = 1'b1;
            else cyc++;
        end
        start = 1'b0; refill = 1'b0;
        check_eq({tag, ".done"}, int'(got), 1);
        check_eq({tag, ".latency"}, cyc, 1 + (en + ec) * (2 + dly));
        check_eq({tag, ".error"}, int'(error), (r != 0) ? 1 : 0);
        check_eq({tag, ".remaining"}, int'(remaining), r);
        check_eq({tag, ".busy_in_done"}, int'(busy), 1);
        check_eq({tag, ".notes"}, note_items - n0, en);
        check_eq({tag, ".coins"}, coin_items - c0, ec);
        check_eq({tag, ".note_stock"}, int'(note_stock), m_ns - en);
        check_eq({tag, ".coin_stock"}, int'(coin_stock), m_cs - ec);
        @(negedge clock);
        check_eq({tag, ".done_pulse"}, int'(done), 0);
        check_eq({tag, ".idle"}, int'(busy), 0);
        check_eq({tag, ".remaining_hold"}, int'(remaining), r);
        m_ns = m_ns - en; m_cs = m_cs - ec;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  cyc, req_cycles, done_seen;
        bit  got;
        m_ns = NOTE_INIT; m_cs = COIN_INIT;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check_eq("rst.busy", int'(busy), 0);
        check_eq("rst.note_req", int'(note_req), 0);
        check_eq("rst.coin_req", int'(coin_req), 0);
        check_eq("rst.done", int'(done), 0);
        check_eq("rst.error", int'(error), 0);
        check_eq("rst.remaining", int'(remaining), 0);
        check_eq("rst.note_stock", int'(note_stock), NOTE_INIT);
        check_eq("rst.coin_stock", int'(coin_stock), COIN_INIT);

        do_payout("p28", 28, 1, 1'b0, 0, 0, 1'b0);
        do_refill(1, 20);
        do_payout("p24", 24, 1, 1'b0, 0, 0, 1'b0);
        do_payout("p7", 7, 0, 1'b0, 0, 0, 1'b0);
        do_payout("p0", 0, 0, 1'b0, 0, 0, 1'b0);
        do_payout("refill_start", 20, 0, 1'b1, 0, 2, 1'b0);
        do_payout("busy_ignore", 26, 2, 1'b1, 3, 10, 1'b1);

        // Unacked request.
        do_refill(10, 20);
        ack_en = 1'b0;
        @(posedge clock); #1;
        start = 1'b1; amount = AMOUNT_W'(10);
        @(posedge clock); #1;
        start = 1'b0;
`ifdef CHANGE_DISPENSER_TIMEOUT_EN
        req_cycles = 0; got = 1'b0; cyc = 0;
        while (!got && cyc < 200) begin
            @(negedge clock);
            if (note_req) req_cycles++;
            if (done) got = 1'b1;
            cyc++;
        end
        check_eq("tmo.done", int'(got), 1);
        check_eq("tmo.req_cycles", req_cycles, TIMEOUT_CYCLES);
        check_eq("tmo.error", int'(error), 1);
        check_eq("tmo.remaining", int'(remaining), 10);
        check_eq("tmo.note_stock", int'(note_stock), m_ns);
        ack_en = 1'b1;
        @(negedge clock);
`else
        done_seen = 0; req_cycles = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) done_seen++;
            if (note_req) req_cycles++;
        end
        check_eq("hold.done_seen", done_seen, 0);
        check_eq("hold.req_cycles", req_cycles, 39);
        check_eq("hold.busy", int'(busy), 1);
        ack_delay = 0;
        ack_en = 1'b1;
        got = 1'b0; cyc = 0;
        while (!got && cyc < 100) begin
            @(negedge clock);
            if (done) got = 1'b1;
            cyc++;
        end
        check_eq("hold.done", int'(got), 1);
        check_eq("hold.error", int'(error), 0);
        check_eq("hold.remaining", int'(remaining), 0);
        check_eq("hold.note_stock", int'(note_stock), m_ns - 1);
        m_ns = m_ns - 1;
        @(negedge clock);
`endif

        // Reset while a coin request is outstanding.
        do_refill(5, 5);
        ack_delay = 3; ack_en = 1'b1;
        @(posedge clock); #1;
        start = 1'b1; amount = AMOUNT_W'(14);
        @(posedge clock); #1;
        start = 1'b0;
        got = 1'b0; cyc = 0;
        while (!got && cyc < 100) begin
            @(negedge clock);
            if (coin_req) got = 1'b1;
            cyc++;
        end
        check_eq("rstmid.coin_req_seen", int'(got), 1);
        check_eq("rstmid.note_dispensed", int'(note_stock), m_ns - 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_eq("rstmid.coin_req", int'(coin_req), 0);
        check_eq("rstmid.busy", int'(busy), 0);
        check_eq("rstmid.done", int'(done), 0);
        check_eq("rstmid.note_stock", int'(note_stock), NOTE_INIT);
        check_eq("rstmid.coin_stock", int'(coin_stock), COIN_INIT);
        done_seen = 0;
        repeat (6) begin
            @(negedge clock);
            if (done) done_seen++;
        end
        check_eq("rstmid.no_done", done_seen, 0);
        m_ns = NOTE_INIT; m_cs = COIN_INIT;
        do_payout("after_rst", 2, 0, 1'b0, 0, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            bit rf, pk;
            int nl, cl, amt, dly;
            rf  = ($urandom_range(0, 3) == 0);
            nl  = $urandom_range(0, 31);
            cl  = $urandom_range(0, 31);
            amt = $urandom_range(0, 63);
            dly = $urandom_range(0, 2);
            pk  = ($urandom_range(0, 3) == 0);
            do_payout("rnd", amt, dly, rf, nl, cl, pk);
        end

        check_eq("never_both_req", both_err, 0);
        check_eq("notes_before_coins", order_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
